wb_stage_ctrl: RTL and testbench

//  Write-back stage controller, next generation of the step-5 write-back decode.

---
 rtl/wb_stage_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_wb_stage_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_ctrl.sv
// Write-back stage controller: decodes a retiring instruction into a register-file
// write, waiting on memory for loads and extracting/extending the loaded lane.
module wb_stage_ctrl #(
   parameter int REG_ADDR_W  = 5,
   parameter int LINK_REG    = 31,
   parameter int TIMEOUT_CYC = 16,
   parameter int CNT_W       = 16,
   parameter bit BIG_ENDIAN  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  flush,
   input  logic [5:0]            opcode,
   input  logic [5:0]            funct,
   input  logic [REG_ADDR_W-1:0] rt,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [31:0]           alu_result,
   input  logic [31:0]           pc_plus4,
   input  logic                  mem_rvalid,
   input  logic [31:0]           mem_rdata,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [31:0]           rf_wdata,
   output logic [1:0]            wb_sel,
   output logic                  timeout_err,
   output logic [CNT_W-1:0]      retired_cnt
);

   localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WCNT_W-1:0]     WAIT_LAST = WCNT_W'(TIMEOUT_CYC - 1);
   localparam logic [REG_ADDR_W-1:0] LINK_ADDR = REG_ADDR_W'(LINK_REG);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [1:0] SEL_ALU  = 2'd0;
   localparam logic [1:0] SEL_MEM  = 2'd1;
   localparam logic [1:0] SEL_LINK = 2'd2;

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t                  state, state_nxt;
   logic [WCNT_W-1:0]       wait_cnt;
   logic [REG_ADDR_W-1:0]   ld_rt_p1;
   logic [5:0]              ld_op_p1;
   logic [1:0]              ld_off_p1;

   logic                    dec_wr_p0, dec_ld_p0;
   logic [REG_ADDR_W-1:0]   dec_addr_p0;
   logic [1:0]              dec_sel_p0;
   logic [31:0]             dec_data_p0;
   logic                    accept_p0, timeout_hit;

   logic                    we_nxt, tmo_nxt, retire_nxt;
   logic [REG_ADDR_W-1:0]   waddr_nxt;
   logic [31:0]             wdata_nxt;
   logic [1:0]              sel_nxt;

   // Lane selection is expressed as a bit offset from the LSB; big-endian reverses it.
   function automatic logic [31:0] extract_load(input logic [5:0]  op,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
      logic [1:0]  blane;
      logic        hlane;
      logic [7:0]  b;
      logic [15:0] h;
      logic signed [31:0] ext;
      blane = BIG_ENDIAN ? ~off : off;
      hlane = BIG_ENDIAN ? ~off[1] : off[1];
      b     = word[{blane, 3'b000} +: 8];
      h     = word[{hlane, 4'b0000} +: 16];
      case (op)
         OP_LB:   ext = {{24{b[7]}}, b};
         OP_LBU:  ext = {24'd0, b};
         OP_LH:   ext = {{16{h[15]}}, h};
         OP_LHU:  ext = {16'd0, h};
         default: ext = word;
      endcase
      return ext;
   endfunction

   assign in_ready    = (state != WAIT_MEM);
   assign accept_p0   = in_valid & in_ready & ~flush;
   assign timeout_hit = (wait_cnt == WAIT_LAST);

   // Stage p0: decode the presented instruction
   always_comb begin
      dec_wr_p0   = 1'b0;
      dec_ld_p0   = 1'b0;
      dec_addr_p0 = rt;
      dec_sel_p0  = SEL_ALU;
      dec_data_p0 = alu_result;
      case (opcode)
         OP_RTYPE: begin
            dec_addr_p0 = rd;
            dec_wr_p0   = (funct != FN_JR);
         end
         OP_JAL: begin
            dec_addr_p0 = LINK_ADDR;
            dec_sel_p0  = SEL_LINK;
            dec_data_p0 = pc_plus4;
            dec_wr_p0   = 1'b1;
         end
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: dec_ld_p0 = 1'b1;
         default: dec_wr_p0 = (opcode[5:3] == 3'b001);
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept_p0 && dec_ld_p0) state_nxt = WAIT_MEM;
         WAIT_MEM: if (flush || mem_rvalid || timeout_hit) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Flush outranks a same-cycle rvalid, and rvalid outranks the timeout.
   always_comb begin
      we_nxt     = 1'b0;
      waddr_nxt  = rf_waddr;
      wdata_nxt  = rf_wdata;
      sel_nxt    = wb_sel;
      tmo_nxt    = timeout_err;
      retire_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (accept_p0 && !dec_ld_p0) begin
               retire_nxt = 1'b1;
               if (dec_wr_p0 && (dec_addr_p0 != '0)) begin
                  we_nxt    = 1'b1;
                  waddr_nxt = dec_addr_p0;
                  wdata_nxt = dec_data_p0;
                  sel_nxt   = dec_sel_p0;
               end
            end
         end
         WAIT_MEM: begin
            if (!flush) begin
               if (mem_rvalid) begin
                  retire_nxt = 1'b1;
                  if (ld_rt_p1 != '0) begin
                     we_nxt    = 1'b1;
                     waddr_nxt = ld_rt_p1;
                     wdata_nxt = extract_load(ld_op_p1, ld_off_p1, mem_rdata);
                     sel_nxt   = SEL_MEM;
                  end
               end else if (timeout_hit) begin
                  tmo_nxt = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Stage p1: registered write port, held load context and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         ld_rt_p1    <= '0;
         ld_op_p1    <= '0;
         ld_off_p1   <= '0;
         rf_we       <= 1'b0;
         rf_waddr    <= '0;
         rf_wdata    <= '0;
         wb_sel      <= '0;
         timeout_err <= 1'b0;
         retired_cnt <= '0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= (state == IDLE) ? '0 : wait_cnt + 1'b1;
         if (accept_p0 && dec_ld_p0) begin
            ld_rt_p1  <= rt;
            ld_op_p1  <= opcode;
            ld_off_p1 <= alu_result[1:0];
         end
         rf_we       <= we_nxt;
         rf_waddr    <= waddr_nxt;
         rf_wdata    <= wdata_nxt;
         wb_sel      <= sel_nxt;
         timeout_err <= tmo_nxt;
         if (retire_nxt) retired_cnt <= retired_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Scoreboard bench for wb_stage_ctrl: expected writes queued at issue, popped on rf_we.
module tb_wb_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, flush = 1'b0;
   logic [5:0]  opcode = '0, funct = '0;
   logic [4:0]  rt = '0, rd = '0;
   logic [31:0] alu_result = '0, pc_plus4 = '0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [1:0]  wb_sel;
   logic        timeout_err;
   logic [15:0] retired_cnt;

   wb_stage_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .opcode(opcode), .funct(funct), .rt(rt), .rd(rd), .alu_result(alu_result),
      .pc_plus4(pc_plus4), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_sel(wb_sel),
      .timeout_err(timeout_err), .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   int ncyc = 0;
   always @(posedge clk) ncyc++;

   typedef struct {
      int          cyc;
      logic [4:0]  a;
      logic [31:0] d;
      logic [1:0]  s;
   } wb_t;

   wb_t sb[$];
   wb_t mon_e;
   int  n_vec = 0, n_err = 0, exp_ret = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [1:0] s);
      wb_t e;
      e.cyc = ncyc + 1;
      e.a   = a;
      e.d   = d;
      e.s   = s;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] t,
                        input logic [4:0] d, input logic [31:0] alu, input logic [31:0] pc,
                        input bit fl);
      @(posedge clk); #1;
      in_valid = 1'b1; flush = fl; mem_rvalid = 1'b0;
      opcode = op; funct = fn; rt = t; rd = d; alu_result = alu; pc_plus4 = pc;
   endtask

   task automatic settle();
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_load(input logic [5:0] op, input logic [4:0] t, input logic [1:0] off,
                          input logic [31:0] data, input int dly, input logic [31:0] exp);
      issue(op, 6'd0, t, 5'd0, {30'd0, off}, 32'd0, 1'b0);
      for (int i = 0; i < dly; i++) begin
         @(posedge clk); #1;
         chk("load_busy_ready", 32'(in_ready), 32'd0);
         in_valid   = (i == 0);
         mem_rvalid = (i == dly - 1);
         mem_rdata  = (i == dly - 1) ? data : 32'hA5A5A5A5;
         if (i == dly - 1) begin
            exp_ret++;
            if (t != 5'd0) push(t, exp, 2'd1);
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; mem_rvalid = 1'b0;
      chk("load_done_ready", 32'(in_ready), 32'd1);
   endtask

   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_we", 32'(rf_waddr), 32'hFFFFFFFF);
         end else begin
            mon_e = sb.pop_front();
            chk("wb_cycle", 32'(ncyc), 32'(mon_e.cyc));
            chk("wb_waddr", 32'(rf_waddr), 32'(mon_e.a));
            chk("wb_wdata", rf_wdata, mon_e.d);
            chk("wb_sel", 32'(wb_sel), 32'(mon_e.s));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_sel", 32'(wb_sel), 32'd0);
      chk("rst_tmo", 32'(timeout_err), 32'd0);
      chk("rst_retired", 32'(retired_cnt), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // addi, then jal followed by an R-type targeting r0
      issue(6'b001000, 6'd0, 5'd5, 5'd21, 32'h0000_1234, 32'd0, 1'b0);
      push(5'd5, 32'h0000_1234, 2'd0); exp_ret++;
      settle();
      chk("retired_addi", 32'(retired_cnt), 32'(exp_ret));

      issue(6'b000011, 6'd0, 5'd2, 5'd3, 32'h1111_0000, 32'h0000_0400, 1'b0);
      push(5'd31, 32'h0000_0400, 2'd2); exp_ret++;
      issue(6'b000000, 6'b100000, 5'd6, 5'd0, 32'h7777_7777, 32'd0, 1'b0);
      exp_ret++;
      settle();
      chk("r0_no_we", 32'(rf_we), 32'd0);
      chk("hold_waddr", 32'(rf_waddr), 32'd31);
      chk("hold_wdata", rf_wdata, 32'h0000_0400);
      chk("retired_r0", 32'(retired_cnt), 32'(exp_ret));

      // assorted decode classes back to back
      issue(6'b000000, 6'b100000, 5'd20, 5'd12, 32'hDEAD_0001, 32'd0, 1'b0);
      push(5'd12, 32'hDEAD_0001, 2'd0);
      issue(6'b000000, 6'b001000, 5'd20, 5'd9, 32'h0BAD_0BAD, 32'd0, 1'b0);
      issue(6'b101011, 6'd0, 5'd3, 5'd4, 32'h0BAD_0BAD, 32'd0, 1'b0);
      issue(6'b001111, 6'd0, 5'd3, 5'd22, 32'hABCD_0000, 32'd0, 1'b0);
      push(5'd3, 32'hABCD_0000, 2'd0);
      issue(6'b000100, 6'd0, 5'd7, 5'd8, 32'h0BAD_0BAD, 32'd0, 1'b0);
      issue(6'b001000, 6'd0, 5'd0, 5'd9, 32'h0BAD_0BAD, 32'd0, 1'b0);
      exp_ret += 6;
      settle();
      chk("retired_mix", 32'(retired_cnt), 32'(exp_ret));

      // loads: lane extraction and extension, big-endian byte order
      do_load(6'b100000, 5'd7,  2'd1, 32'h11F2_3344, 3,  32'hFFFF_FFF2);
      do_load(6'b100100, 5'd8,  2'd1, 32'h11F2_3344, 1,  32'h0000_00F2);
      do_load(6'b100000, 5'd9,  2'd3, 32'h11F2_3344, 2,  32'h0000_0044);
      do_load(6'b100001, 5'd10, 2'd0, 32'h8001_7FFF, 1,  32'hFFFF_8001);
      do_load(6'b100001, 5'd11, 2'd3, 32'h8001_7FFF, 2,  32'h0000_7FFF);
      do_load(6'b100101, 5'd12, 2'd2, 32'h8001_F00D, 1,  32'h0000_F00D);
      do_load(6'b100101, 5'd13, 2'd1, 32'h8001_F00D, 1,  32'h0000_8001);
      do_load(6'b100011, 5'd14, 2'd0, 32'hCAFE_BABE, 16, 32'hCAFE_BABE);
      do_load(6'b100000, 5'd0,  2'd0, 32'h11F2_3344, 2,  32'h0000_0000);
      settle();
      chk("tmo_clear_after_loads", 32'(timeout_err), 32'd0);
      chk("retired_loads", 32'(retired_cnt), 32'(exp_ret));

      // load abandoned after the full wait window
      issue(6'b100011, 6'd0, 5'd4, 5'd0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("tmo_busy_ready", 32'(in_ready), 32'd0);
         if (i == 15) chk("tmo_not_yet", 32'(timeout_err), 32'd0);
      end
      @(posedge clk); #1;
      chk("tmo_ready", 32'(in_ready), 32'd1);
      chk("tmo_set", 32'(timeout_err), 32'd1);
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      settle();
      chk("retired_tmo", 32'(retired_cnt), 32'(exp_ret));

      // flush beats a same-cycle rvalid; flush also kills a presented instruction
      issue(6'b100011, 6'd0, 5'd6, 5'd0, 32'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      flush = 1'b0; mem_rvalid = 1'b0;
      chk("flush_ready", 32'(in_ready), 32'd1);
      issue(6'b001000, 6'd0, 5'd15, 5'd0, 32'h0BAD_0BAD, 32'd0, 1'b1);
      settle();
      chk("retired_flush", 32'(retired_cnt), 32'(exp_ret));
      issue(6'b001001, 6'd0, 5'd16, 5'd0, 32'h0000_BEEF, 32'd0, 1'b0);
      push(5'd16, 32'h0000_BEEF, 2'd0); exp_ret++;
      settle();
      chk("tmo_sticky", 32'(timeout_err), 32'd1);

      // asynchronous reset while waiting on memory
      issue(6'b100011, 6'd0, 5'd8, 5'd0, 32'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_waddr", 32'(rf_waddr), 32'd0);
      chk("arst_wdata", rf_wdata, 32'd0);
      chk("arst_tmo", 32'(timeout_err), 32'd0);
      chk("arst_retired", 32'(retired_cnt), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_ret = 0;
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
      settle();
      chk("arst_rvalid_ignored", 32'(retired_cnt), 32'd0);
      issue(6'b001000, 6'd0, 5'd1, 5'd0, 32'h0000_0042, 32'd0, 1'b0);
      push(5'd1, 32'h0000_0042, 2'd0); exp_ret++;
      settle();
      chk("retired_post_rst", 32'(retired_cnt), 32'(exp_ret));

      settle();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
